rst_seq_ctrl: RTL

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

---
 rtl/rst_seq_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronizes rst, then releases N_DOM reset domains one by one in index order.
// Optional ack handshake per domain is enabled with `define RST_SEQ_ACK_EN.
module rst_seq_ctrl #(
    parameter int N_DOM       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw_rst_req,
`ifdef RST_SEQ_ACK_EN
    input  logic [N_DOM-1:0] dom_ack,
    output logic             timeout_err,
`endif
    output logic [N_DOM-1:0] rst_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int KW      = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam logic [KW-1:0] K_LAST    = KW'(N_DOM - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES);

    localparam logic [2:0] S_ASSERT  = 3'd0;
    localparam logic [2:0] S_HOLD    = 3'd1;
    localparam logic [2:0] S_RELEASE = 3'd2;
`ifdef RST_SEQ_ACK_EN
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT);
`endif
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync;
    logic [2:0]             state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [N_DOM-1:0]       rst_out_d;
    logic                   start_hold;
    logic [KW-1:0]          start_idx;
`ifdef RST_SEQ_ACK_EN
    logic                   err_d;
`endif

    assign rst_sync = sync_q[SYNC_STAGES-1];
    assign cnt_inc  = cnt_q + CW'(1);
    assign busy     = |rst_out;
    assign done     = ~busy;

    // The edge that starts a hold interval is itself the first counted hold edge,
    // so with HOLD_CYCLES == 1 the domain releases on that very edge.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        rst_out_d  = rst_out;
        start_hold = 1'b0;
        start_idx  = k_q;
`ifdef RST_SEQ_ACK_EN
        err_d      = timeout_err;
`endif
        if (rst_sync || sw_rst_req) begin
            state_d   = S_ASSERT;
            k_d       = '0;
            cnt_d     = '0;
            rst_out_d = '1;
`ifdef RST_SEQ_ACK_EN
            err_d     = 1'b0;
`endif
        end else begin
            case (state_q)
                S_ASSERT: begin
                    start_hold = 1'b1;
                    start_idx  = '0;
                end
                S_HOLD: begin
                    if (cnt_inc == HOLD_LAST) begin
                        rst_out_d[k_q] = 1'b0;
                        state_d        = S_RELEASE;
                        cnt_d          = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_RELEASE: begin
                    if (k_q == K_LAST) begin
                        state_d = S_DONE;
                    end else begin
`ifdef RST_SEQ_ACK_EN
                        state_d = S_WAIT_ACK;
                        cnt_d   = '0;
`else
                        start_hold = 1'b1;
                        start_idx  = k_q + KW'(1);
`endif
                    end
                end
`ifdef RST_SEQ_ACK_EN
                S_WAIT_ACK: begin
                    if (dom_ack[k_q]) begin
                        start_hold = 1'b1;
                        start_idx  = k_q + KW'(1);
                    end else if (cnt_inc == ACK_LAST) begin
                        err_d      = 1'b1;
                        start_hold = 1'b1;
                        start_idx  = k_q + KW'(1);
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
`endif
                S_DONE:  state_d = S_DONE;
                default: state_d = S_ASSERT;
            endcase

            if (start_hold) begin
                k_d = start_idx;
                if (HOLD_CYCLES == 1) begin
                    rst_out_d[start_idx] = 1'b0;
                    state_d              = S_RELEASE;
                    cnt_d                = '0;
                end else begin
                    state_d = S_HOLD;
                    cnt_d   = CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '1;
            state_q <= S_ASSERT;
            k_q     <= '0;
            cnt_q   <= '0;
            rst_out <= '1;
`ifdef RST_SEQ_ACK_EN
            timeout_err <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], 1'b0};
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            rst_out <= rst_out_d;
`ifdef RST_SEQ_ACK_EN
            timeout_err <= err_d;
`endif
        end
    end

endmodule
